serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 150 +++++++++++++++
 tb/tb_serial_mag_comparator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Purpose : bit-serial magnitude comparator (MSB first), unsigned or two's-complement.
// Latency : WIDTH cycles from accept to DONE, or WIDTH-i when EARLY_EXIT and first difference at bit i.
// Backpres: start is only sampled in IDLE; requests while busy or done are dropped.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request; accepted only in IDLE, captures a, b, signed_mode
//   signed_mode, a, b   operands and compare mode
//   busy                high while bits are being scanned
//   done                one-cycle pulse when eq/gt/lt/ne have just been updated
//   eq, gt, lt, ne      registered result, held until the next completion
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             ne
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);
  localparam logic EE = (EARLY_EXIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic [IW-1:0]    idx_q, idx_d;
  // A difference already seen in full-scan mode, and its direction.
  logic             dec_q, dec_d;
  logic             dgt_q, dgt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             ne_q, ne_d;

  logic bit_a, bit_b, bit_diff, cur_gt, fin_diff, fin_gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      dgt_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      ne_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      dgt_q   <= dgt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      ne_q    <= ne_d;
    end
  end

  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    bit_diff = bit_a ^ bit_b;
    // In signed mode the sign bit has inverted weight: A=1 there means A is negative.
    cur_gt   = (sm_q && (idx_q == MSB_IDX)) ? ~bit_a : bit_a;
    // The first difference wins; later bits only matter if nothing differed yet.
    fin_diff = dec_q | bit_diff;
    fin_gt   = dec_q ? dgt_q : cur_gt;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    dgt_d   = dgt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    ne_d    = ne_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = MSB_IDX;
          dec_d   = 1'b0;
          dgt_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if ((EE && bit_diff) || (idx_q == '0)) begin
          eq_d    = ~fin_diff;
          ne_d    = fin_diff;
          gt_d    = fin_diff & fin_gt;
          lt_d    = fin_diff & ~fin_gt;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
          if (bit_diff && !dec_q) begin
            dec_d = 1'b1;
            dgt_d = cur_gt;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign ne   = ne_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Purpose : scoreboard bench for serial_mag_comparator (8-bit early-exit, 8-bit full-scan, 2-bit).
// Latency : expected done cycle and busy length come from a reference model per request.
// Backpres: requests are issued only when the target instance is idle.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] sm_v = '0;
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];
  logic [2:0] busy_v, done_v, eq_v, gt_v, lt_v, ne_v;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bcnt [3];
  int dcnt [3];

  typedef struct {
    int   due;
    int   blen;
    logic eq, gt, lt, ne;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_e8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .ne(ne_v[0]));

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_f8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_v[1]),
    .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .ne(ne_v[1]));

  serial_mag_comparator #(.WIDTH(2), .EARLY_EXIT(1)) u_e2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_v[2]),
    .a(a_v[2][1:0]), .b(b_v[2][1:0]), .busy(busy_v[2]), .done(done_v[2]),
    .eq(eq_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .ne(ne_v[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wof(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic bit eeof(input int k);
    return (k != 1);
  endfunction

  // Reference: plain integer compare; latency from position of the top differing bit.
  function automatic exp_t model(input int w, input bit ee, input logic [7:0] a,
                                 input logic [7:0] b, input bit sm);
    exp_t e;
    int ua, ub, sa, sb, x, lat;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    sa = ua;
    sb = ub;
    if (sm) begin
      if (ua >= (1 << (w - 1))) sa = ua - (1 << w);
      if (ub >= (1 << (w - 1))) sb = ub - (1 << w);
    end
    x = ua ^ ub;
    lat = w;
    if (ee && x != 0) begin
      for (int i = 0; i < w; i++) if (((x >> i) & 1) == 1) lat = w - i;
    end
    e.due  = lat;
    e.blen = lat;
    e.eq   = (sa == sb);
    e.gt   = (sa > sb);
    e.lt   = (sa < sb);
    e.ne   = (sa != sb);
    return e;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) bcnt[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k] && done_v[k]) chk($sformatf("dut%0d_busy_done_overlap", k), 1, 0);
        if (busy_v[k]) bcnt[k]++;
        if (done_v[k]) begin
          dcnt[k]++;
          if (qsize(k) == 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_done actual=done expected=no_done (t=%0t)", k, $time);
          end else begin
            e = qpop(k);
            chk($sformatf("dut%0d_done_cycle", k), cyc, e.due);
            chk($sformatf("dut%0d_busy_len", k), bcnt[k], e.blen);
            chk($sformatf("dut%0d_eq", k), int'(eq_v[k]), int'(e.eq));
            chk($sformatf("dut%0d_gt", k), int'(gt_v[k]), int'(e.gt));
            chk($sformatf("dut%0d_lt", k), int'(lt_v[k]), int'(e.lt));
            chk($sformatf("dut%0d_ne", k), int'(ne_v[k]), int'(e.ne));
          end
          bcnt[k] = 0;
        end
      end
    end
  end

  task automatic wait_idle(input int k);
    int n = 0;
    @(negedge clk);
    while ((busy_v[k] || done_v[k]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("dut%0d_idle_timeout", k), 1, 0);
  endtask

  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input bit sm);
    exp_t e;
    int n0;
    wait_idle(k);
    start_v[k] = 1'b1;
    a_v[k] = a;
    b_v[k] = b;
    sm_v[k] = sm;
    @(negedge clk);
    n0 = cyc;
    start_v[k] = 1'b0;
    // Operand changes after accept must not disturb the result.
    a_v[k] = 8'($urandom);
    b_v[k] = 8'($urandom);
    sm_v[k] = 1'($urandom);
    e = model(wof(k), eeof(k), a, b, sm);
    e.due = n0 + e.due;
    qpush(k, e);
  endtask

  initial begin
    int d0, n;
    for (int k = 0; k < 3; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
      bcnt[k] = 0;
      dcnt[k] = 0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_dut%0d_busy", k), int'(busy_v[k]), 0);
      chk($sformatf("rst_dut%0d_done", k), int'(done_v[k]), 0);
      chk($sformatf("rst_dut%0d_eqgtltne", k),
          int'({eq_v[k], gt_v[k], lt_v[k], ne_v[k]}), 0);
    end
    #20 rst_n = 1'b1;

    // Directed cases.
    issue(0, 8'h00, 8'h00, 1'b0);
    issue(0, 8'h80, 8'h7F, 1'b0);
    issue(0, 8'h80, 8'h7F, 1'b1);
    issue(0, 8'h05, 8'h04, 1'b0);
    issue(1, 8'h05, 8'h04, 1'b0);
    issue(1, 8'h85, 8'h04, 1'b0);
    issue(1, 8'h80, 8'h7F, 1'b1);

    // Start held during SHIFT must not cause a second accept.
    wait_idle(0);
    d0 = dcnt[0];
    issue(0, 8'h10, 8'h20, 1'b0);
    start_v[0] = 1'b1;
    a_v[0] = 8'hFF;
    b_v[0] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("start_in_shift_done_count", dcnt[0] - d0, 1);

    // Random traffic on the 8-bit instances alongside the exhaustive 2-bit sweep.
    fork
      begin
        repeat (40) issue(0, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        repeat (40) issue(1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        for (int s = 0; s < 2; s++)
          for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
              issue(2, 8'(x), 8'(y), 1'(s));
      end
    join

    // Reset in the middle of a scan aborts it without a done pulse.
    for (int k = 0; k < 3; k++) wait_idle(k);
    start_v[0] = 1'b1;
    a_v[0] = 8'h3C;
    b_v[0] = 8'h3C;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("midshift_busy_before_rst", int'(busy_v[0]), 1);
    d0 = dcnt[0];
    #2 rst_n = 1'b0;
    #1;
    chk("midshift_rst_busy", int'(busy_v[0]), 0);
    chk("midshift_rst_done", int'(done_v[0]), 0);
    chk("midshift_rst_eqgtltne", int'({eq_v[0], gt_v[0], lt_v[0], ne_v[0]}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midshift_no_done", dcnt[0] - d0, 0);
    issue(0, 8'h03, 8'h03, 1'b0);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
